uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 40000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 1000, line baud rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer depth in bytes (power of two, at least 2).
REQ-004 SHALL have port clk_40k, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port din, input, 8, byte to transmit.
REQ-007 SHALL have port din_vld, input, 1, din valid, active high.
REQ-008 SHALL have port din_rdy, output, 1, buffer can accept a byte, active high.
REQ-009 SHALL have port bit_out, output, 1, serial line, idle high.
REQ-010 SHALL have port busy, output, 1, high while a frame is in flight or the buffer is non-empty.

Function
REQ-011 SHALL derive BIT_CYCLES = CLK_FREQ/UART_BPS (40 at defaults); the baud counter width SHALL be clog2(BIT_CYCLES), and the counter SHALL count 0..BIT_CYCLES-1 then wrap to 0.
REQ-012 SHALL accept a byte on a rising edge where din_vld and din_rdy are both high; din_vld while din_rdy is low SHALL be ignored, and the data SHALL NOT be stored.
REQ-013 din_rdy SHALL be high exactly when the buffer occupancy is below FIFO_DEPTH, decoded combinationally from the registered occupancy.
REQ-014 A push and a pop on the same edge SHALL leave the occupancy unchanged; a pop SHALL occur only when the buffer is non-empty.
REQ-015 The buffer SHALL be first-in first-out, and the read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 SHALL implement a state machine with states IDLE, START, DATA and STOP.
REQ-017 IDLE: on an edge with the buffer non-empty, pop the head into a shift register, go to START, and drive bit_out 0; otherwise bit_out stays 1.
REQ-018 START: hold bit_out 0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
REQ-019 DATA: drive data bits LSB first, each for BIT_CYCLES cycles; after bit 7 completes, go to STOP.
REQ-020 STOP: hold bit_out 1 for BIT_CYCLES cycles; at the end, if the buffer is non-empty, pop and enter START directly with no idle cycle, else enter IDLE.
REQ-021 bit_out SHALL be registered, and a frame SHALL last exactly 10*BIT_CYCLES cycles (400 at defaults).
REQ-022 Latency: a byte accepted into an empty buffer while in IDLE SHALL cause bit_out to fall on the next rising edge.
REQ-023 busy SHALL equal (state != IDLE) OR (occupancy != 0).
REQ-024 The accept path SHALL remain open during transmission, so bytes can be queued while a frame is in flight.

Reset
REQ-025 While rst_n is low: bit_out=1, din_rdy=1, busy=0, state=IDLE, occupancy=0, pointers=0, counters=0, shift register=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with bit_out forced to 1 asynchronously; queued bytes SHALL be discarded.
REQ-027 No byte SHALL be accepted or transmitted on the first edge after rst_n deasserts unless din_vld is high on that edge.

Structure
REQ-028 CLK_FREQ/UART_BPS defaults, the BIT_CYCLES derivation and the state encodings SHALL reside in a shared package, uart_pkg, for reuse by the receive path.
REQ-029 The buffer SHALL be a sub-module, uart_tx_fifo (synchronous, single clock, with push/pop/full/empty/count), instantiated once.

Verification
REQ-030 Single byte: push 0xA5 after reset -> bit_out 0 for 40 cycles from the next edge, then 1,0,1,0,0,1,0,1 for 40 cycles each, then 1 for 40; busy falls 400 cycles after bit_out first falls.
REQ-031 Burst with din_vld held and bytes 0x01..0x06 -> 0x01..0x05 accepted on consecutive edges; din_rdy low until byte 0x01's stop bit ends, then 0x06 accepted; six frames back-to-back over 2400 cycles with no idle gap.
REQ-032 Offer 0xFF while full -> din_rdy=0, byte not transmitted; the queue order of earlier bytes is unchanged.
REQ-033 Reset during data bit 3 of 0x3C with two bytes queued -> bit_out=1, busy=0, din_rdy=1 at once; bit_out stays 1 for 1000 cycles after release.
REQ-034 Mid-bit sampling model (sample at cycle 20 of each bit) on 0x00, 0xFF, 0x5A -> decoded bytes match and every stop bit reads 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line rates, bit-period derivation and the
// frame state encoding used by both the transmit and receive paths.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 40000;
  localparam int UART_BPS_DEF = 1000;

  function automatic int bit_cycles(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  localparam int BIT_CYCLES_DEF = bit_cycles(CLK_FREQ_DEF, UART_BPS_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO for the transmit path; pointers wrap modulo DEPTH
// (a power of two), and push/pop are ignored when full/empty respectively.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are sent
// LSB first, back-to-back frames when the queue stays non-empty.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int UART_BPS   = UART_BPS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_40k,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic       bit_out,
  output logic       busy
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, UART_BPS);
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  uart_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             bit_out_nxt;
  logic             bit_end;

  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk_40k),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign din_rdy = !fifo_full;
  assign push    = din_vld && din_rdy;
  assign busy    = (state != IDLE) || (fifo_count != '0);
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk_40k or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      bit_out <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      bit_out <= bit_out_nxt;
    end
  end

  // bit_out_nxt is the line level for the cycle following this edge, so a
  // pop in IDLE drops the line on the very next edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_end ? '0 : cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    bit_out_nxt = bit_out;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_out_nxt = 1'b1;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shreg_nxt   = fifo_dout;
          state_nxt   = START;
          bit_out_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          bit_out_nxt = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt   = STOP;
            bit_out_nxt = 1'b1;
          end else begin
            shreg_nxt   = shreg >> 1;
            bit_idx_nxt = bit_idx + 3'd1;
            bit_out_nxt = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            shreg_nxt   = fifo_dout;
            state_nxt   = START;
            bit_out_nxt = 1'b0;
          end else begin
            state_nxt   = IDLE;
            bit_out_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_out_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level line model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_uart_tx;

  localparam int BIT   = 40;
  localparam int FRAME = 400;
  localparam int DEPTH = 4;

  logic       clk_40k = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] din     = 8'h00;
  logic       din_vld = 1'b0;
  logic       din_rdy;
  logic       bit_out;
  logic       busy;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  uart_tx #(
    .CLK_FREQ   (40000),
    .UART_BPS   (1000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_40k (clk_40k),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .din_rdy (din_rdy),
    .bit_out (bit_out),
    .busy    (busy)
  );

  always #5 clk_40k = ~clk_40k;
  always @(posedge clk_40k) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // Line model: a queue of accepted bytes and the position inside the frame
  // currently on the wire. A new frame begins as soon as the line is free.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_act = 1'b0;
  int         m_pos = 0;

  initial begin
    bit         acc;
    logic [7:0] d;
    forever begin
      @(posedge clk_40k or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_act = 1'b0;
        m_pos = 0;
      end else begin
        acc = din_vld && (m_q.size() < DEPTH);
        d   = din;
        if (m_act) begin
          m_pos++;
          if (m_pos == FRAME) begin
            if (m_q.size() != 0) begin
              m_cur = m_q.pop_front();
              m_pos = 0;
            end else begin
              m_act = 1'b0;
            end
          end
        end else if (m_q.size() != 0) begin
          m_cur = m_q.pop_front();
          m_act = 1'b1;
          m_pos = 0;
        end
        if (acc) m_q.push_back(d);
      end
    end
  end

  function automatic logic exp_bit();
    int k;
    if (!m_act) return 1'b1;
    k = m_pos / BIT;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clk_40k);
      check("line_bit_out", bit_out, exp_bit());
      check("line_busy", busy, m_act || (m_q.size() != 0));
      check("line_din_rdy", din_rdy, m_q.size() < DEPTH);
    end
  end

  // Receiver-style decode: find the falling edge, sample at cycle 20 of each bit.
  task automatic decode_frame(output logic [7:0] data, output logic stop,
                              output int fall_cyc, output bit ok);
    int n = 0;
    data = '0; stop = 1'b0; fall_cyc = 0; ok = 1'b1;
    @(negedge clk_40k);
    while (bit_out !== 1'b0 && n < 3000) begin
      @(negedge clk_40k);
      n++;
    end
    if (bit_out !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    fall_cyc = cyc;
    repeat (BIT/2) @(negedge clk_40k);
    if (bit_out !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (BIT) @(negedge clk_40k);
      data[k] = bit_out;
    end
    repeat (BIT) @(negedge clk_40k);
    stop = bit_out;
  endtask

  // Holds din_vld high, advancing to the next byte after each accepting edge.
  task automatic drive_seq(input logic [7:0] seq[8], input int n, output int acc[8]);
    int   idx   = 0;
    int   guard = 0;
    logic r;
    for (int i = 0; i < 8; i++) acc[i] = 0;
    @(posedge clk_40k); #1;
    din     = seq[0];
    din_vld = 1'b1;
    while (idx < n && guard < 3000) begin
      @(negedge clk_40k);
      r = din_rdy;
      @(posedge clk_40k); #1;
      guard++;
      if (r) begin
        acc[idx] = cyc;
        idx++;
        if (idx < n) din = seq[idx];
      end
    end
    din_vld = 1'b0;
    if (idx < n) check("accept_timeout", idx, n);
  endtask

  task automatic xfer(input logic [7:0] seq[8], input int n, input bit offer_ff,
                      output int acc[8], output logic [7:0] got[8], output int fall[8],
                      output bit stop_all, output bit ok_all, output bit rdy_seen);
    stop_all = 1'b1; ok_all = 1'b1; rdy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got[i]  = '0;
      fall[i] = 0;
    end
    fork
      begin
        drive_seq(seq, n, acc);
        if (offer_ff) begin
          din     = 8'hFF;
          din_vld = 1'b1;
          repeat (10) begin
            @(negedge clk_40k);
            rdy_seen = rdy_seen | din_rdy;
          end
          din_vld = 1'b0;
        end
      end
      begin
        for (int i = 0; i < n; i++) begin
          logic s;
          bit   ok;
          decode_frame(got[i], s, fall[i], ok);
          if (s !== 1'b1) stop_all = 1'b0;
          if (!ok) begin
            ok_all = 1'b0;
            break;
          end
        end
      end
    join
  endtask

  task automatic wait_idle(output int t);
    int n = 0;
    @(negedge clk_40k);
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk_40k);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", busy, 0);
    t = cyc;
  endtask

  initial begin
    logic [7:0] seq  [8];
    int         acc  [8];
    logic [7:0] got  [8];
    int         fall [8];
    bit         stop_all, ok_all, rdy_seen;
    int         t_idle, n, bad, target;

    // Reset state and quiet release
    repeat (3) @(posedge clk_40k); #1;
    check("rst_bit_out", bit_out, 1);
    check("rst_din_rdy", din_rdy, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk_40k); #1;
    check("release_bit_out", bit_out, 1);
    check("release_busy", busy, 0);

    // Single byte 0xA5
    seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(seq, 1, 1'b0, acc, got, fall, stop_all, ok_all, rdy_seen);
    check("single_found", ok_all, 1);
    check("single_data", got[0], 8'hA5);
    check("single_stop", stop_all, 1);
    check("single_latency", fall[0] - acc[0], 1);
    wait_idle(t_idle);
    check("single_busy_len", t_idle - fall[0], 400);

    // Burst 0x01..0x06 with din_vld held
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    xfer(seq, 6, 1'b0, acc, got, fall, stop_all, ok_all, rdy_seen);
    check("burst_found", ok_all, 1);
    check("burst_stop", stop_all, 1);
    for (int i = 0; i < 6; i++) begin
      check("burst_data", got[i], 8'(i + 1));
      check("burst_gap", fall[i] - fall[0], 400 * i);
    end
    for (int i = 1; i < 5; i++) check("burst_accept_consec", acc[i] - acc[0], i);
    check("burst_sixth_accept", acc[5] - acc[0], 402);
    wait_idle(t_idle);
    check("burst_total", t_idle - fall[0], 2400);

    // Offer 0xFF while the buffer is full
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
    xfer(seq, 5, 1'b1, acc, got, fall, stop_all, ok_all, rdy_seen);
    check("full_rdy_low", rdy_seen, 0);
    check("full_found", ok_all, 1);
    check("full_stop", stop_all, 1);
    check("full_d0", got[0], 8'h11);
    check("full_d1", got[1], 8'h22);
    check("full_d2", got[2], 8'h33);
    check("full_d3", got[3], 8'h44);
    check("full_d4", got[4], 8'h55);
    wait_idle(t_idle);
    check("full_total", t_idle - fall[0], 2000);

    // Reset during data bit 3 of 0x3C with two bytes queued
    seq = '{8'h3C, 8'h81, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    drive_seq(seq, 3, acc);
    target = acc[0] + 1 + 4*BIT + 15;
    n = 0;
    while (cyc != target && n < 1000) begin
      @(negedge clk_40k);
      n++;
    end
    check("abort_reach_bit3", cyc, target);
    check("abort_bit3_level", bit_out, 1);
    check("abort_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_bit_out", bit_out, 1);
    check("abort_busy", busy, 0);
    check("abort_din_rdy", din_rdy, 1);
    repeat (3) @(posedge clk_40k); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk_40k);
      if (bit_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 0);

    // Mid-bit decode of 0x00, 0xFF, 0x5A
    seq = '{8'h00, 8'hFF, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xfer(seq, 3, 1'b0, acc, got, fall, stop_all, ok_all, rdy_seen);
    check("decode_found", ok_all, 1);
    check("decode_stop", stop_all, 1);
    check("decode_d0", got[0], 8'h00);
    check("decode_d1", got[1], 8'hFF);
    check("decode_d2", got[2], 8'h5A);
    wait_idle(t_idle);
    check("decode_total", t_idle - fall[0], 1200);
    repeat (20) @(negedge clk_40k);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
